// File: rtl/spdif_lock_controller.sv
// S/PDIF lock supervisor: steps through four bit-length threshold presets while hunting,
// qualifies lock from the preamble sequence and drives mute and decoder restart.
module spdif_lock_controller #(
  parameter int unsigned LOCK_SUBFRAMES = 16,
  parameter int unsigned UNLOCK_ERRORS  = 2,
  parameter int unsigned TIMEOUT        = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sync_b,
  input  logic       sync_w,
  input  logic       sync_m,
  output logic [1:0] rate_sel,
  output logic [7:0] t1,
  output logic [7:0] t2,
  output logic [7:0] t3,
  output logic       audio_locked,
  output logic       mute,
  output logic       decoder_restart
);

  localparam logic [0:0]  ST_HUNT   = 1'b0;
  localparam logic [0:0]  ST_LOCKED = 1'b1;
  localparam logic [1:0]  PRE_NONE  = 2'd0;
  localparam logic [1:0]  PRE_B     = 2'd1;
  localparam logic [1:0]  PRE_W     = 2'd2;
  localparam logic [1:0]  PRE_M     = 2'd3;
  localparam logic [11:0] TMO_LAST  = 12'(TIMEOUT - 32'd1);
  localparam logic [7:0]  GOOD_LAST = 8'(LOCK_SUBFRAMES - 32'd1);
  localparam logic [7:0]  ERR_LAST  = 8'(UNLOCK_ERRORS - 32'd1);

  // {t1, t2, t3} for a preset index, fastest bit clock last.
  function automatic logic [23:0] preset_thresholds(input logic [1:0] idx);
    logic [23:0] thr;
    case (idx)
      2'd0:    thr = {8'd20, 8'd38, 8'd42};
      2'd1:    thr = {8'd16, 8'd30, 8'd32};
      2'd2:    thr = {8'd10, 8'd19, 8'd21};
      2'd3:    thr = {8'd5,  8'd9,  8'd10};
      default: thr = {8'd20, 8'd38, 8'd42};
    endcase
    return thr;
  endfunction

  logic [0:0]  state_r;
  logic [1:0]  rate_sel_r;
  logic [7:0]  t1_r, t2_r, t3_r;
  logic        audio_locked_r, mute_r, decoder_restart_r;
  logic [7:0]  good_cnt_r, err_cnt_r;
  logic [11:0] tmo_cnt_r;
  logic [1:0]  last_pre_r;

  logic [2:0]  sync_vec_s;
  logic [1:0]  pre_type_s;
  logic        any_pre_s, single_s, seq_ok_s, valid_s, invalid_s, timeout_s, unlock_s;

  logic [0:0]  nxt_state_s;
  logic [1:0]  nxt_rate_sel_s, nxt_last_pre_s;
  logic        nxt_locked_s, nxt_mute_s, nxt_restart_s;
  logic [7:0]  nxt_good_cnt_s, nxt_err_cnt_s;
  logic [11:0] nxt_tmo_cnt_s;
  logic [23:0] thr_s;

  assign sync_vec_s = {sync_b, sync_w, sync_m};
  assign thr_s      = preset_thresholds(nxt_rate_sel_s);

  // Classify this cycle's preamble activity against the last accepted preamble.
  always_comb begin
    any_pre_s = ena & (sync_vec_s != 3'b000);
    case (sync_vec_s)
      3'b100: begin pre_type_s = PRE_B;    single_s = 1'b1; end
      3'b010: begin pre_type_s = PRE_W;    single_s = 1'b1; end
      3'b001: begin pre_type_s = PRE_M;    single_s = 1'b1; end
      default: begin pre_type_s = PRE_NONE; single_s = 1'b0; end
    endcase
    case (last_pre_r)
      PRE_NONE:     seq_ok_s = 1'b1;
      PRE_W:        seq_ok_s = (pre_type_s == PRE_B) || (pre_type_s == PRE_M);
      PRE_B, PRE_M: seq_ok_s = (pre_type_s == PRE_W);
      default:      seq_ok_s = 1'b0;
    endcase
    valid_s   = any_pre_s & single_s & seq_ok_s;
    invalid_s = any_pre_s & ~valid_s;
    // A preamble in the same cycle suppresses the timeout.
    timeout_s = ena & ~any_pre_s & (tmo_cnt_r == TMO_LAST);
    unlock_s  = (state_r == ST_LOCKED) &
                (timeout_s | (invalid_s & (err_cnt_r == ERR_LAST)));
  end

  // Next-state decisions; with ena low everything holds except the restart pulse.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_rate_sel_s = rate_sel_r;
    nxt_locked_s   = audio_locked_r;
    nxt_mute_s     = mute_r;
    nxt_restart_s  = 1'b0;
    nxt_good_cnt_s = good_cnt_r;
    nxt_err_cnt_s  = err_cnt_r;
    nxt_tmo_cnt_s  = tmo_cnt_r;
    nxt_last_pre_s = last_pre_r;
    if (ena) begin
      if (any_pre_s || timeout_s) begin
        nxt_tmo_cnt_s = 12'd0;
      end else begin
        nxt_tmo_cnt_s = tmo_cnt_r + 12'd1;
      end
      if (valid_s) begin
        nxt_last_pre_s = pre_type_s;
      end else if (invalid_s) begin
        nxt_last_pre_s = PRE_NONE;
      end else begin
        nxt_last_pre_s = last_pre_r;
      end
      case (state_r)
        ST_HUNT: begin
          if (valid_s) begin
            if (good_cnt_r == GOOD_LAST) begin
              nxt_state_s    = ST_LOCKED;
              nxt_locked_s   = 1'b1;
              nxt_err_cnt_s  = 8'd0;
              nxt_good_cnt_s = 8'd0;
            end else begin
              nxt_good_cnt_s = good_cnt_r + 8'd1;
            end
          end else if (invalid_s) begin
            nxt_good_cnt_s = 8'd0;
          end else if (timeout_s) begin
            nxt_rate_sel_s = rate_sel_r + 2'd1;
            nxt_restart_s  = 1'b1;
            nxt_good_cnt_s = 8'd0;
            nxt_last_pre_s = PRE_NONE;
          end else begin
            nxt_good_cnt_s = good_cnt_r;
          end
        end
        ST_LOCKED: begin
          // rate_sel is kept on unlock so the current preset is retried first.
          if (unlock_s) begin
            nxt_state_s    = ST_HUNT;
            nxt_locked_s   = 1'b0;
            nxt_mute_s     = 1'b1;
            nxt_restart_s  = 1'b1;
            nxt_good_cnt_s = 8'd0;
            nxt_err_cnt_s  = 8'd0;
            nxt_last_pre_s = PRE_NONE;
          end else if (valid_s) begin
            nxt_err_cnt_s = 8'd0;
            if (pre_type_s == PRE_B) begin
              nxt_mute_s = 1'b0;
            end else begin
              nxt_mute_s = mute_r;
            end
          end else if (invalid_s) begin
            nxt_err_cnt_s = err_cnt_r + 8'd1;
          end else begin
            nxt_err_cnt_s = err_cnt_r;
          end
        end
        default: begin
          nxt_state_s  = ST_HUNT;
          nxt_locked_s = 1'b0;
          nxt_mute_s   = 1'b1;
        end
      endcase
    end else begin
      nxt_tmo_cnt_s = tmo_cnt_r;
    end
  end

  // State and output registers; reset restores the hunting, muted defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_HUNT;
      rate_sel_r        <= 2'd0;
      t1_r              <= 8'd20;
      t2_r              <= 8'd38;
      t3_r              <= 8'd42;
      audio_locked_r    <= 1'b0;
      mute_r            <= 1'b1;
      decoder_restart_r <= 1'b0;
      good_cnt_r        <= 8'd0;
      err_cnt_r         <= 8'd0;
      tmo_cnt_r         <= 12'd0;
      last_pre_r        <= PRE_NONE;
    end else begin
      state_r           <= nxt_state_s;
      rate_sel_r        <= nxt_rate_sel_s;
      t1_r              <= thr_s[23:16];
      t2_r              <= thr_s[15:8];
      t3_r              <= thr_s[7:0];
      audio_locked_r    <= nxt_locked_s;
      mute_r            <= nxt_mute_s;
      decoder_restart_r <= nxt_restart_s;
      good_cnt_r        <= nxt_good_cnt_s;
      err_cnt_r         <= nxt_err_cnt_s;
      tmo_cnt_r         <= nxt_tmo_cnt_s;
      last_pre_r        <= nxt_last_pre_s;
    end
  end

  assign rate_sel        = rate_sel_r;
  assign t1              = t1_r;
  assign t2              = t2_r;
  assign t3              = t3_r;
  assign audio_locked    = audio_locked_r;
  assign mute            = mute_r;
  assign decoder_restart = decoder_restart_r;

endmodule

// File: tb/tb_spdif_lock_controller.sv
// Bench for spdif_lock_controller: directed scenarios plus random preamble traffic,
// checked every cycle against a behavioural model of the lock rules.
module tb_spdif_lock_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       sync_b = 1'b0, sync_w = 1'b0, sync_m = 1'b0;
  logic [1:0] rate_sel;
  logic [7:0] t1, t2, t3;
  logic       audio_locked, mute, decoder_restart;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  spdif_lock_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sync_b(sync_b), .sync_w(sync_w), .sync_m(sync_m),
    .rate_sel(rate_sel), .t1(t1), .t2(t2), .t3(t3),
    .audio_locked(audio_locked), .mute(mute), .decoder_restart(decoder_restart)
  );

  // Behavioural model: preamble letters, plain counters, preset tables.
  int  m_rate, m_good, m_err, m_tmo;
  bit  m_locked, m_mute, m_restart;
  byte m_last;
  int  T1[4] = '{20, 16, 10, 5};
  int  T2[4] = '{38, 30, 19, 9};
  int  T3[4] = '{42, 32, 21, 10};
  bit  use_m = 1'b1;

  function automatic bit follows(byte prev, byte cur);
    if (cur == 8'd0) return 1'b0;
    if (prev == 8'd0) return 1'b1;
    if (prev == "W") return (cur == "B") || (cur == "M");
    return cur == "W";
  endfunction

  task automatic model_reset();
    m_rate = 0; m_good = 0; m_err = 0; m_tmo = 0;
    m_locked = 1'b0; m_mute = 1'b1; m_restart = 1'b0; m_last = 8'd0;
  endtask

  task automatic model_unlock();
    m_locked = 1'b0; m_mute = 1'b1; m_restart = 1'b1;
    m_good = 0; m_err = 0; m_last = 8'd0;
  endtask

  task automatic model_step(bit b, bit w, bit m, bit e);
    int  n;
    byte cur;
    bit  ok;
    m_restart = 1'b0;
    if (!e) return;
    n = int'(b) + int'(w) + int'(m);
    if (n == 0) begin
      m_tmo++;
      if (m_tmo == 4095) begin
        m_tmo = 0;
        if (m_locked) model_unlock();
        else begin
          m_rate = (m_rate + 1) % 4; m_restart = 1'b1; m_good = 0; m_last = 8'd0;
        end
      end
      return;
    end
    m_tmo = 0;
    cur = (n != 1) ? 8'd0 : (b ? "B" : (w ? "W" : "M"));
    ok = follows(m_last, cur);
    m_last = ok ? cur : 8'd0;
    if (!m_locked) begin
      if (ok) begin
        m_good++;
        if (m_good == 16) begin m_locked = 1'b1; m_err = 0; m_good = 0; end
      end else m_good = 0;
    end else if (ok) begin
      m_err = 0;
      if (cur == "B") m_mute = 1'b0;
    end else begin
      m_err++;
      if (m_err == 2) model_unlock();
    end
  endtask

  // Per-cycle compare: sample inputs at the rising edge, advance model and check at the falling edge.
  initial begin : cmp_proc
    bit sb, sw, sm, se, sr;
    forever begin
      @(posedge clk);
      sb = sync_b; sw = sync_w; sm = sync_m; se = ena; sr = rst_n;
      @(negedge clk);
      if (!sr || !rst_n) model_reset();
      else model_step(sb, sw, sm, se);
      n_cmp++;
      if (int'(rate_sel) != m_rate || int'(t1) != T1[m_rate] || int'(t2) != T2[m_rate] ||
          int'(t3) != T3[m_rate] || audio_locked != m_locked || mute != m_mute ||
          decoder_restart != m_restart) begin
        n_mis++;
        $display("FAIL cycle_model t=%0t: got rate=%0d thr=%0d/%0d/%0d lock=%0d mute=%0d rst=%0d, expected rate=%0d thr=%0d/%0d/%0d lock=%0d mute=%0d rst=%0d",
                 $time, rate_sel, t1, t2, t3, audio_locked, mute, decoder_restart,
                 m_rate, T1[m_rate], T2[m_rate], T3[m_rate], m_locked, m_mute, m_restart);
      end
    end
  end

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(bit b, bit w, bit m, bit e);
    sync_b = b; sync_w = w; sync_m = m; ena = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Next preamble of the B,W,M,W,... pattern given the model's last accepted one.
  task automatic send_valid();
    byte t;
    if (m_last == 8'd0) t = "B";
    else if (m_last == "W") begin t = use_m ? "M" : "B"; use_m = !use_m; end
    else t = "W";
    cyc(t == "B", t == "W", t == "M", 1'b1);
  endtask

  initial begin
    int r, k;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rate", int'(rate_sel), 0);
    check("reset_t1", int'(t1), 20);
    check("reset_t2", int'(t2), 38);
    check("reset_t3", int'(t3), 42);
    check("reset_locked", int'(audio_locked), 0);
    check("reset_mute", int'(mute), 1);
    check("reset_restart", int'(decoder_restart), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      idle(4094);
      check("pre_timeout_restart", int'(decoder_restart), 0);
      check("pre_timeout_rate", int'(rate_sel), i);
      idle(1);
      check("timeout_rate", int'(rate_sel), (i + 1) % 4);
      check("timeout_restart", int'(decoder_restart), 1);
      if (i == 0) begin
        check("preset1_t1", int'(t1), 16);
        check("preset1_t2", int'(t2), 30);
        check("preset1_t3", int'(t3), 32);
      end
      if (i == 3) begin
        check("wrap_t1", int'(t1), 20);
        check("wrap_t2", int'(t2), 38);
        check("wrap_t3", int'(t3), 42);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("restart_one_cycle", int'(decoder_restart), 0);
    end

    for (int i = 0; i < 15; i++) begin send_valid(); idle(99); end
    send_valid();
    check("lock_on_16th", int'(audio_locked), 1);
    check("lock_mute_held", int'(mute), 1);
    check("lock_rate", int'(rate_sel), 0);
    idle(99);
    send_valid();
    check("unmute_on_b", int'(mute), 0);
    idle(3);

    cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(5); cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("unlock_locked", int'(audio_locked), 0);
    check("unlock_mute", int'(mute), 1);
    check("unlock_restart", int'(decoder_restart), 1);
    check("unlock_rate_kept", int'(rate_sel), 0);
    idle(1);
    check("unlock_restart_drop", int'(decoder_restart), 0);

    idle(2);
    repeat (16) begin send_valid(); idle(3); end
    check("relock", int'(audio_locked), 1);
    repeat (10) begin cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(2); send_valid(); idle(2); end
    check("lock_held_alt_err", int'(audio_locked), 1);

    cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(1); cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("unlock2", int'(audio_locked), 0);
    idle(4094);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("boundary_no_restart", int'(decoder_restart), 0);
    check("boundary_rate", int'(rate_sel), 0);
    idle(1);
    repeat (9) begin send_valid(); idle(1); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(1);
    repeat (15) begin send_valid(); idle(1); end
    check("no_lock_after_15", int'(audio_locked), 0);
    send_valid();
    check("lock_after_16", int'(audio_locked), 1);

    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      else if (r == 1) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      else cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("ena_low_locked", int'(audio_locked), 1);
    check("ena_low_rate", int'(rate_sel), 0);
    check("ena_low_restart", int'(decoder_restart), 0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) idle(4100);
      r = $urandom_range(0, 99);
      if (r < 70) idle(1);
      else if (r < 88) begin send_valid(); idle(1); end
      else if (r < 93) begin
        k = $urandom_range(0, 2);
        cyc(k == 0, k == 1, k == 2, 1'b1); idle(1);
      end else if (r < 96) begin
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1); idle(1);
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    idle(2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(1); cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(1);
    repeat (16) begin send_valid(); idle(1); end
    check("lock_before_reset", int'(audio_locked), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_locked", int'(audio_locked), 0);
    check("async_reset_mute", int'(mute), 1);
    check("async_reset_restart", int'(decoder_restart), 0);
    check("async_reset_rate", int'(rate_sel), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
